// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, constants and rotating-priority search for the PIC service stage
package pic_pkg;

  localparam int         PIC_LEVELS     = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic {IDLE, ACK2} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } prio_t;

  // Walk from lowest to highest priority so the last hit is the highest-priority set bit.
  function automatic prio_t rotate_priority(input logic [7:0] vec, input logic [2:0] lowest);
    prio_t      r;
    logic [2:0] idx;
    r = '0;
    for (int i = PIC_LEVELS; i >= 1; i--) begin
      idx = lowest + 3'(i);
      if (vec[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - picks the highest-priority candidate ranked strictly above every in-service level
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] candidate,
  input  logic [7:0] isr,
  input  logic [2:0] lowest,
  output logic [2:0] winner,
  output logic       valid
);

  prio_t      cand_hit;
  prio_t      isr_hit;
  logic [2:0] cand_rank;
  logic [2:0] isr_rank;

  // Rank 0 is the level just above the pointer, rank 7 is the pointer itself.
  always_comb begin
    cand_hit  = rotate_priority(candidate, lowest);
    isr_hit   = rotate_priority(isr, lowest);
    cand_rank = cand_hit.idx - lowest - 3'd1;
    isr_rank  = isr_hit.idx - lowest - 3'd1;
    winner    = cand_hit.idx;
    valid     = cand_hit.found && (!isr_hit.found || (cand_rank < isr_rank));
  end

endmodule

// File: rtl/pic_priority_service.sv
// rtl/pic_priority_service.sv - priority resolution, INT generation, two-pulse INTA acknowledge and EOI handling
module pic_priority_service
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt_req_reg,
  input  logic [7:0] interrupt_mask,
  input  logic       inta_pulse,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] clear_ir_line,
  output logic       freeze,
  output logic [7:0] in_service_reg,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  state_t     state;
  logic [2:0] lowest;
  logic [2:0] sel;
  logic       spurious;

  logic [2:0] win_level;
  logic       win_valid;
  logic [2:0] ns_level;
  logic       ns_valid;

  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] eoi_clear;
  logic       rot_valid;
  logic [2:0] rot_level;
  logic [7:0] isr_next;

  pic_priority_resolver u_winner (
    .candidate (interrupt_req_reg & ~interrupt_mask),
    .isr       (in_service_reg),
    .lowest    (lowest),
    .winner    (win_level),
    .valid     (win_valid)
  );

  // With no blocking ISR the resolver simply returns the highest-priority in-service level.
  pic_priority_resolver u_eoi_target (
    .candidate (in_service_reg),
    .isr       (8'h00),
    .lowest    (lowest),
    .winner    (ns_level),
    .valid     (ns_valid)
  );

  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    eoi_clear = '0;
    rot_valid = 1'b0;
    rot_level = '0;
    if (state == IDLE && inta_pulse && win_valid)
      set_mask = 8'(1) << win_level;
    if (state == ACK2 && inta_pulse && auto_eoi && !spurious) begin
      clr_mask = 8'(1) << sel;
      if (rotate_on_eoi) begin
        rot_valid = 1'b1;
        rot_level = sel;
      end
    end
    if (eoi_cmd) begin
      if (eoi_specific) begin
        if (in_service_reg[eoi_level]) eoi_clear = 8'(1) << eoi_level;
        if (rotate_on_eoi && in_service_reg[eoi_level]) begin
          rot_valid = 1'b1;
          rot_level = eoi_level;
        end
      end else if (ns_valid) begin
        eoi_clear = 8'(1) << ns_level;
        if (rotate_on_eoi) begin
          rot_valid = 1'b1;
          rot_level = ns_level;
        end
      end
    end
    // A set of the same level in this cycle overrides any clear.
    isr_next = (in_service_reg & ~(eoi_clear | clr_mask)) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lowest         <= 3'd7;
      sel            <= '0;
      spurious       <= 1'b0;
      in_service_reg <= '0;
      int_out        <= 1'b0;
      freeze         <= 1'b0;
      clear_ir_line  <= '0;
      vector_out     <= '0;
      vector_valid   <= 1'b0;
    end else begin
      in_service_reg <= isr_next;
      clear_ir_line  <= '0;
      vector_valid   <= 1'b0;
      if (rot_valid) lowest <= rot_level;
      case (state)
        IDLE: begin
          int_out <= win_valid;
          freeze  <= 1'b0;
          if (inta_pulse) begin
            sel           <= win_valid ? win_level : SPURIOUS_LEVEL;
            spurious      <= !win_valid;
            clear_ir_line <= set_mask;
            freeze        <= 1'b1;
            int_out       <= 1'b0;
            state         <= ACK2;
          end
        end
        ACK2: begin
          int_out <= 1'b0;
          freeze  <= 1'b1;
          if (inta_pulse) begin
            vector_out   <= {vector_base, sel};
            vector_valid <= 1'b1;
            freeze       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
